// File: rtl/mem_access_stage.sv
// MEM stage of the RV32I pipeline: byte-lane steering for the data-memory bus,
// load extension, request/grant/response handshake with watchdog abort.
module mem_access_stage #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [2:0]  funct3M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataExtM,
    output logic        StallM,
    output logic        MisalignM,
    output logic        BusErrM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;

    logic        access, is_load, is_byte, is_half, is_word, illegal, misalign;
    logic        valid, timeout_hit;
    logic [1:0]  off;
    logic [31:0] rd_shift, ext_data;
    logic [15:0] rd_half;

    // Access decode and lane steering
    always_comb begin
        access   = MemReadM | MemWriteM;
        is_load  = MemReadM;
        off      = ALUResultM[1:0];
        is_byte  = (funct3M[1:0] == 2'b00);
        is_half  = (funct3M[1:0] == 2'b01);
        is_word  = (funct3M == 3'b010);
        illegal  = (funct3M == 3'b011) || (funct3M == 3'b110) || (funct3M == 3'b111);
        misalign = illegal || (is_half && off[0]) || (is_word && (off != 2'b00));
        valid    = access && !misalign;

        dmem_we    = MemWriteM && !MemReadM;
        dmem_addr  = {ALUResultM[31:2], 2'b00};
        dmem_be    = 4'b0000;
        dmem_wdata = WriteDataM;
        if (is_byte) begin
            dmem_be    = 4'b0001 << off;
            dmem_wdata = {4{WriteDataM[7:0]}};
        end else if (is_half) begin
            dmem_be    = 4'b0011 << off;
            dmem_wdata = {2{WriteDataM[15:0]}};
        end else if (is_word) begin
            dmem_be    = 4'b1111;
        end

        rd_shift = dmem_rdata >> {off, 3'b000};
        rd_half  = ALUResultM[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        if (is_byte)
            ext_data = {{24{!funct3M[2] && rd_shift[7]}}, rd_shift[7:0]};
        else if (is_half)
            ext_data = {{16{!funct3M[2] && rd_half[15]}}, rd_half};
        else
            ext_data = dmem_rdata;

        MisalignM = !rst && access && misalign;
    end

    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == 8'(TIMEOUT - 1));

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        dmem_req     = 1'b0;
        StallM       = 1'b0;
        BusErrM      = 1'b0;
        ReadDataExtM = 32'h0;
        case (state_q)
            IDLE: begin
                cnt_d = 8'd0;
                if (valid) begin
                    dmem_req = 1'b1;
                    if (dmem_gnt) begin
                        if (is_load) begin
                            state_d = WAIT;
                            StallM  = 1'b1;
                        end
                    end else begin
                        state_d = REQ;
                        StallM  = 1'b1;
                    end
                end
            end
            REQ: begin
                dmem_req = 1'b1;
                cnt_d    = cnt_q + 8'd1;
                // A granted store is a completion and beats the watchdog.
                if (dmem_gnt && !is_load) begin
                    state_d = IDLE;
                end else if (timeout_hit) begin
                    BusErrM = 1'b1;
                    state_d = IDLE;
                end else begin
                    StallM = 1'b1;
                    if (dmem_gnt) state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + 8'd1;
                if (dmem_rvalid) begin
                    ReadDataExtM = ext_data;
                    state_d      = IDLE;
                end else if (timeout_hit) begin
                    BusErrM = 1'b1;
                    state_d = IDLE;
                end else begin
                    StallM = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_d == IDLE) cnt_d = 8'd0;
        if (rst) begin
            state_d      = IDLE;
            cnt_d        = 8'd0;
            dmem_req     = 1'b0;
            StallM       = 1'b0;
            BusErrM      = 1'b0;
            ReadDataExtM = 32'h0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboarded bench for mem_access_stage: lane steering, load extension,
// stalls, misalignment, watchdog abort and mid-transaction reset.
module tb_mem_access_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        MemReadM, MemWriteM;
    logic [2:0]  funct3M;
    logic [31:0] ALUResultM, WriteDataM;
    logic [31:0] ReadDataExtM;
    logic        StallM, MisalignM, BusErrM;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_rdata;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] sb_q[$];

    always #5 clk = ~clk;

    mem_access_stage #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .MemReadM(MemReadM), .MemWriteM(MemWriteM), .funct3M(funct3M),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .ReadDataExtM(ReadDataExtM), .StallM(StallM), .MisalignM(MisalignM), .BusErrM(BusErrM),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
        MemReadM = rd; MemWriteM = wr; funct3M = f3; ALUResultM = a; WriteDataM = wd;
    endtask

    task automatic bus(input logic g, input logic rv, input logic [31:0] rd);
        dmem_gnt = g; dmem_rvalid = rv; dmem_rdata = rd;
    endtask

    task automatic nxt();
        @(posedge clk); #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        bus(1'b0, 1'b0, 32'h0);
    endtask

    // Load with immediate grant and rvalid in the following cycle
    task automatic load(input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] rd, input logic [31:0] exp);
        drive(1'b1, 1'b0, f3, a, 32'h0);
        bus(1'b1, 1'b0, 32'h0);
        sb_q.push_back(exp);
        mid();
        chk("ld_gnt_stall", StallM, 1'b1);
        chk("ld_gnt_req", dmem_req, 1'b1);
        nxt();
        bus(1'b0, 1'b1, rd);
        mid();
        chk("ld_done_stall", StallM, 1'b0);
        chk("ld_done_req", dmem_req, 1'b0);
        nxt();
        idle();
    endtask

    // Load response monitor
    always @(negedge clk) begin
        if (!rst && MemReadM && dmem_rvalid && !StallM && !BusErrM && !MisalignM) begin
            logic [31:0] exp;
            exp = (sb_q.size() != 0) ? sb_q.pop_front() : 32'hxxxxxxxx;
            chk("ld_data", ReadDataExtM, exp);
        end
    end

    initial begin
        drive(1'b1, 1'b0, 3'b011, 32'h3001, 32'h0);
        bus(1'b1, 1'b0, 32'h0);
        mid();
        chk("rst_req", dmem_req, 1'b0);
        chk("rst_stall", StallM, 1'b0);
        chk("rst_mis", MisalignM, 1'b0);
        chk("rst_buserr", BusErrM, 1'b0);
        chk("rst_rdext", ReadDataExtM, 32'h0);
        nxt();
        rst = 1'b0;
        idle();

        // Stores with immediate grant
        drive(1'b0, 1'b1, 3'b000, 32'h1003, 32'hAABBCCDD);
        bus(1'b1, 1'b0, 32'h0);
        mid();
        chk("sb_be", dmem_be, 4'b1000);
        chk("sb_wdata", dmem_wdata, 32'hDDDDDDDD);
        chk("sb_addr", dmem_addr, 32'h1000);
        chk("sb_req_we", {dmem_req, dmem_we}, 2'b11);
        chk("sb_stall", StallM, 1'b0);
        nxt();
        drive(1'b0, 1'b1, 3'b001, 32'h1002, 32'hAABBCCDD);
        mid();
        chk("sh_be", dmem_be, 4'b1100);
        chk("sh_wdata", dmem_wdata, 32'hCCDDCCDD);
        chk("sh_stall", StallM, 1'b0);
        nxt();
        drive(1'b0, 1'b1, 3'b010, 32'h1004, 32'h11223344);
        mid();
        chk("sw_be", dmem_be, 4'b1111);
        chk("sw_wdata", dmem_wdata, 32'h11223344);
        nxt();

        // Store with a one-cycle grant delay
        drive(1'b0, 1'b1, 3'b000, 32'h1001, 32'h000000A5);
        bus(1'b0, 1'b0, 32'h0);
        mid();
        chk("sb_wait_stall", StallM, 1'b1);
        chk("sb_wait_be", dmem_be, 4'b0010);
        nxt();
        bus(1'b1, 1'b0, 32'h0);
        mid();
        chk("sb_gnt_stall", StallM, 1'b0);
        chk("sb_gnt_req", dmem_req, 1'b1);
        nxt();
        idle();

        // Loads: sign/zero extension across lanes
        load(3'b000, 32'h2001, 32'h000080FF, 32'hFFFFFF80);
        load(3'b100, 32'h2001, 32'h000080FF, 32'h00000080);
        load(3'b000, 32'h2003, 32'h7F000000, 32'h0000007F);
        load(3'b101, 32'h2000, 32'h80011234, 32'h00001234);
        load(3'b010, 32'h3000, 32'hDEADBEEF, 32'hDEADBEEF);

        // LH with grant delayed three cycles; completes on the last watchdog count
        drive(1'b1, 1'b0, 3'b001, 32'h2002, 32'h0);
        bus(1'b0, 1'b0, 32'h0);
        sb_q.push_back(32'hFFFF8001);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) bus(1'b1, 1'b0, 32'h0);
            mid();
            chk($sformatf("lh_req%0d", i), dmem_req, 1'b1);
            chk($sformatf("lh_addr%0d", i), dmem_addr, 32'h2000);
            chk($sformatf("lh_be%0d", i), dmem_be, 4'b1100);
            chk($sformatf("lh_stall%0d", i), StallM, 1'b1);
            nxt();
        end
        bus(1'b0, 1'b1, 32'h80011234);
        mid();
        chk("lh_done_stall", StallM, 1'b0);
        chk("lh_done_buserr", BusErrM, 1'b0);
        nxt();
        idle();

        // Misaligned and illegal accesses
        drive(1'b1, 1'b0, 3'b010, 32'h3002, 32'h0);
        bus(1'b1, 1'b0, 32'h0);
        mid();
        chk("lw_mis", MisalignM, 1'b1);
        chk("lw_mis_req", dmem_req, 1'b0);
        chk("lw_mis_stall", StallM, 1'b0);
        nxt();
        drive(1'b0, 1'b1, 3'b011, 32'h3000, 32'h0);
        mid();
        chk("f3_011_mis", MisalignM, 1'b1);
        chk("f3_011_req", dmem_req, 1'b0);
        nxt();
        drive(1'b1, 1'b0, 3'b101, 32'h2001, 32'h0);
        mid();
        chk("lhu_mis", MisalignM, 1'b1);
        nxt();
        drive(1'b0, 1'b0, 3'b111, 32'h3001, 32'h0);
        mid();
        chk("noacc_mis", MisalignM, 1'b0);
        nxt();
        idle();

        // Watchdog abort of a granted load
        drive(1'b1, 1'b0, 3'b010, 32'h4000, 32'h0);
        bus(1'b1, 1'b0, 32'h0);
        mid();
        chk("to_gnt_stall", StallM, 1'b1);
        nxt();
        bus(1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            mid();
            chk($sformatf("to_wait_stall%0d", i), StallM, 1'b1);
            chk($sformatf("to_wait_buserr%0d", i), BusErrM, 1'b0);
            nxt();
        end
        mid();
        chk("to_buserr", BusErrM, 1'b1);
        chk("to_stall", StallM, 1'b0);
        chk("to_rdext", ReadDataExtM, 32'h0);
        nxt();
        idle();
        bus(1'b0, 1'b1, 32'hFFFFFFFF);
        mid();
        chk("late_rdext", ReadDataExtM, 32'h0);
        chk("late_buserr", BusErrM, 1'b0);
        chk("late_req", dmem_req, 1'b0);
        nxt();
        drive(1'b0, 1'b1, 3'b010, 32'h4000, 32'h5A5A5A5A);
        bus(1'b1, 1'b0, 32'h0);
        mid();
        chk("post_to_idle_stall", StallM, 1'b0);
        chk("post_to_idle_req", dmem_req, 1'b1);
        nxt();
        idle();

        // Reset while waiting for read data, then a clean load
        drive(1'b1, 1'b0, 3'b010, 32'h5000, 32'h0);
        bus(1'b1, 1'b0, 32'h0);
        mid();
        nxt();
        bus(1'b0, 1'b0, 32'h0);
        rst = 1'b1;
        mid();
        chk("wrst_req", dmem_req, 1'b0);
        chk("wrst_stall", StallM, 1'b0);
        nxt();
        rst = 1'b0;
        bus(1'b1, 1'b0, 32'h0);
        sb_q.push_back(32'h12345678);
        mid();
        chk("post_rst_req", dmem_req, 1'b1);
        chk("post_rst_stall", StallM, 1'b1);
        nxt();
        bus(1'b0, 1'b1, 32'h12345678);
        mid();
        chk("post_rst_done", StallM, 1'b0);
        nxt();
        idle();

        mid();
        chk("sb_left", 32'(sb_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
